// File: rtl/frame_packer.sv
// Packs 32-bit channel samples into 8-channel frames with a double-buffered valid/ack output.
// Optional PACKER_ERRCNT_EN adds a saturating 16-bit sync-error counter output.
module frame_packer #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      valid,
    input  logic                      ack,
    output logic [CHANNELS*WIDTH-1:0] pdata,
    output logic                      syncErrIncr,
    output logic                      droppedIncr
`ifdef PACKER_ERRCNT_EN
    ,
    output logic [15:0]               syncErrCnt
`endif
);

    localparam int CW = $clog2(CHANNELS);
    localparam int FW = CHANNELS * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        HUNT,
        FILL,
        FULL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [FW-1:0]   pdata_q, pdata_d;
    logic            valid_q, valid_d;
    logic            sync_q, sync_d;
    logic            drop_q, drop_d;
    logic            accept;
    logic            out_free;

    assign in_ready = enable && !rst && (state_q != FULL);
    assign accept   = in_valid && in_ready;
    assign out_free = !valid_q || ack;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        fill_d  = fill_q;
        pdata_d = pdata_q;
        valid_d = valid_q;
        sync_d  = 1'b0;
        drop_d  = 1'b0;
        if (valid_q && ack) valid_d = 1'b0;
        if (!enable) begin
            // Flush: pending and partial frames vanish silently, pdata is kept.
            state_d = HUNT;
            ch_d    = '0;
            fill_d  = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (accept && in_sof) begin
                        fill_d           = '0;
                        fill_d[WIDTH-1:0] = in_data;
                        ch_d             = CW'(1);
                        state_d          = FILL;
                    end else if (accept) begin
                        drop_d = 1'b1;
                    end
                end
                FILL: begin
                    if (accept && in_sof && ch_q != '0) begin
                        // SOF mid-frame (including on the last slot) restarts the frame.
                        fill_d            = '0;
                        fill_d[WIDTH-1:0] = in_data;
                        ch_d              = CW'(1);
                        sync_d            = 1'b1;
                    end else if (accept) begin
                        fill_d[ch_q*WIDTH +: WIDTH] = in_data;
                        if (ch_q == LAST) begin
                            ch_d    = '0;
                            state_d = FULL;
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_free) begin
                        pdata_d = fill_q;
                        valid_d = 1'b1;
                        ch_d    = '0;
                        state_d = FILL;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            ch_q    <= '0;
            fill_q  <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            fill_q  <= fill_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            drop_q  <= drop_d;
        end
    end

    assign valid       = valid_q;
    assign pdata       = pdata_q;
    assign syncErrIncr = sync_q;
    assign droppedIncr = drop_q;

`ifdef PACKER_ERRCNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sync_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign syncErrCnt = cnt_q;
`endif

endmodule

// File: tb/tb_frame_packer.sv
// Directed self-checking bench for frame_packer.
// Define PACKER_ERRCNT_EN to also exercise the sync-error counter.
module tb_frame_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sof = 1'b0;
    logic [31:0]  in_data = '0;
    logic         valid;
    logic         ack = 1'b0;
    logic [255:0] pdata;
    logic         syncErrIncr;
    logic         droppedIncr;
`ifdef PACKER_ERRCNT_EN
    logic [15:0]  syncErrCnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    frame_packer dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .valid       (valid),
        .ack         (ack),
        .pdata       (pdata),
        .syncErrIncr (syncErrIncr),
        .droppedIncr (droppedIncr)
`ifdef PACKER_ERRCNT_EN
        ,
        .syncErrCnt  (syncErrCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sof, input logic [31:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    function automatic logic [255:0] frm(input logic [31:0] off);
        logic [255:0] r;
        for (int c = 0; c < 8; c++) r[c*32 +: 32] = 32'h11111111 * c + off;
        return r;
    endfunction

    task automatic send_frame(input logic [31:0] off);
        for (int c = 0; c < 8; c++) send(c == 0, 32'h11111111 * c + off);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset values, first frame latency
        enable = 1'b1;
        rst    = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pdata", pdata, 0);
        chk("rst_sync", syncErrIncr, 0);
        chk("rst_drop", droppedIncr, 0);
        rst = 1'b0;
        #1;
        chk("hunt_in_ready", in_ready, 1);
        send_frame(0);
        chk("full_in_ready", in_ready, 0);
        chk("full_valid", valid, 0);
        tick();
        chk("f1_valid", valid, 1);
        chk("f1_lo", pdata[31:0], 0);
        chk("f1_hi", pdata[255:224], 32'h77777777);
        chk("f1_pdata", pdata, frm(0));

        // 2: second frame waits for ack, then back-to-back reload
        send_frame(1);
        tick();
        chk("wait_in_ready", in_ready, 0);
        chk("wait_valid", valid, 1);
        chk("wait_pdata", pdata, frm(0));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("b2b_valid", valid, 1);
        chk("b2b_pdata", pdata, frm(1));
        chk("b2b_in_ready", in_ready, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_clear", valid, 0);
        chk("ack_keep", pdata, frm(1));

        // 3: samples without SOF are dropped while hunting
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 32'hBAD0_0000 + i);
            chk("drop_pulse", droppedIncr, 1);
            chk("drop_valid", valid, 0);
        end
        tick();
        chk("drop_end", droppedIncr, 0);
        send_frame(2);
        tick();
        chk("hunt_valid", valid, 1);
        chk("hunt_pdata", pdata, frm(2));
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // 4: misplaced SOF after 5 samples, and on the last slot
        for (int c = 0; c < 5; c++) send(c == 0, 32'hDEAD0000 + c);
        send(1'b1, 32'h3);
        chk("sync_pulse", syncErrIncr, 1);
`ifdef PACKER_ERRCNT_EN
        chk("sync_cnt1", syncErrCnt, 1);
`endif
        for (int c = 1; c < 8; c++) send(1'b0, 32'h11111111 * c + 3);
        chk("sync_off", syncErrIncr, 0);
        tick();
        chk("resync_pdata", pdata, frm(3));
        chk("resync_valid", valid, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int c = 0; c < 7; c++) send(c == 0, 32'hCAFE0000 + c);
        send(1'b1, 32'h6);
        chk("last_sof_sync", syncErrIncr, 1);
        chk("last_sof_notfull", in_ready, 1);
        for (int c = 1; c < 8; c++) send(1'b0, 32'h11111111 * c + 6);
        tick();
        chk("last_sof_pdata", pdata, frm(6));
`ifdef PACKER_ERRCNT_EN
        chk("sync_cnt2", syncErrCnt, 2);
`endif
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // 5: flush mid-fill and while a frame is pending
        do_reset();
        for (int c = 0; c < 5; c++) send(c == 0, 32'hF00D0000 + c);
        enable = 1'b0;
        tick();
        chk("flush_valid", valid, 0);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_sync", syncErrIncr, 0);
        enable = 1'b1;
        send_frame(4);
        tick();
        chk("clean_pdata", pdata, frm(4));
        enable = 1'b0;
        tick();
        chk("flush2_valid", valid, 0);
        chk("flush2_keep", pdata, frm(4));
        enable = 1'b1;
        send(1'b0, 32'h1234);
        chk("resume_hunt", droppedIncr, 1);
        send_frame(5);
        tick();
        chk("resume_pdata", pdata, frm(5));
        chk("resume_valid", valid, 1);

`ifdef PACKER_ERRCNT_EN
        // 6: counter saturation and reset
        do_reset();
        in_valid = 1'b1;
        in_sof   = 1'b1;
        for (int i = 0; i < 65538; i++) tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("cnt_sat", syncErrCnt, 16'hFFFF);
        enable = 1'b0;
        tick();
        chk("cnt_en_hold", syncErrCnt, 16'hFFFF);
        do_reset();
        chk("cnt_rst", syncErrCnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
